// File: rtl/conv2d_update_sequencer_pkg.sv
// Shared constants, FSM encodings and helpers for the conv2d kernel-window update sequencer.
package conv2d_update_sequencer_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  // Field widths of the default layer configuration (32x32 image, 4 channels, 3x3 kernel).
  localparam int DEF_COORD_BITS  = 8;
  localparam int DEF_IN_CHANNELS = 4;
  localparam int DEF_TAP_BITS    = 4;

  typedef logic [DEF_IN_CHANNELS-1:0] spike_vector_t;

  typedef struct packed {
    logic [DEF_COORD_BITS-1:0] x;
    logic [DEF_COORD_BITS-1:0] y;
  } vec2_t;

  typedef struct packed {
    logic [DEF_COORD_BITS-1:0] x;
    logic [DEF_COORD_BITS-1:0] y;
    logic [DEF_TAP_BITS-1:0]   tap;
    spike_vector_t             spikes;
    logic                      last;
  } kernel_update_t;

  function automatic int tap_bits(input int k);
    int n;
    n = k * k;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv2d_update_sequencer_if.sv
// Event-in / update-out handshake bundle of the kernel-window sequencer.
interface conv2d_update_sequencer_if
  import conv2d_update_sequencer_pkg::*;
#(
  parameter int COORD_BITS  = 8,
  parameter int IN_CHANNELS = 4,
  parameter int KERNEL_SIZE = 3,
  parameter int TAP_BITS    = tap_bits(KERNEL_SIZE)
) ();

  logic                   event_valid;
  logic                   event_ready;
  logic [COORD_BITS-1:0]  event_x;
  logic [COORD_BITS-1:0]  event_y;
  logic [IN_CHANNELS-1:0] event_spikes;

  logic                   upd_valid;
  logic                   upd_ready;
  logic [COORD_BITS-1:0]  upd_x;
  logic [COORD_BITS-1:0]  upd_y;
  logic [TAP_BITS-1:0]    upd_tap;
  logic [IN_CHANNELS-1:0] upd_spikes;
  logic                   upd_last;

  modport master (
    output event_valid, event_x, event_y, event_spikes, upd_ready,
    input  event_ready, upd_valid, upd_x, upd_y, upd_tap, upd_spikes, upd_last
  );

  modport slave (
    input  event_valid, event_x, event_y, event_spikes, upd_ready,
    output event_ready, upd_valid, upd_x, upd_y, upd_tap, upd_spikes, upd_last
  );

endinterface

// File: rtl/conv2d_update_sequencer_chk.sv
// Elaboration-time parameter sanity checks for the kernel-window sequencer.
module conv2d_update_sequencer_chk #(
  parameter int COORD_BITS  = 8,
  parameter int IMG_WIDTH   = 32,
  parameter int IMG_HEIGHT  = 32,
  parameter int KERNEL_SIZE = 3
) ();

  if (KERNEL_SIZE < 1 || (KERNEL_SIZE % 2) == 0) begin : g_bad_kernel
    $error("conv2d_update_sequencer: KERNEL_SIZE must be odd and >= 1");
  end

  if (IMG_WIDTH > (1 << COORD_BITS) || IMG_HEIGHT > (1 << COORD_BITS)) begin : g_bad_image
    $error("conv2d_update_sequencer: image dimensions exceed coordinate range");
  end

endmodule

// File: rtl/conv2d_update_sequencer_kernel_window_clip.sv
// Clips the KERNEL_SIZE x KERNEL_SIZE window around an event to the image and flags out-of-image events.
module conv2d_update_sequencer_kernel_window_clip #(
  parameter int COORD_BITS  = 8,
  parameter int IMG_WIDTH   = 32,
  parameter int IMG_HEIGHT  = 32,
  parameter int KERNEL_SIZE = 3
) (
  input  logic [COORD_BITS-1:0] x,
  input  logic [COORD_BITS-1:0] y,
  output logic [COORD_BITS-1:0] x_lo,
  output logic [COORD_BITS-1:0] x_hi,
  output logic [COORD_BITS-1:0] y_lo,
  output logic [COORD_BITS-1:0] y_hi,
  output logic                  oob
);

  localparam int SW = COORD_BITS + 2;
  localparam logic signed [SW-1:0] ZERO_S  = '0;
  localparam logic signed [SW-1:0] OFF_S   = SW'(KERNEL_SIZE / 2);
  localparam logic signed [SW-1:0] W_S     = SW'(IMG_WIDTH);
  localparam logic signed [SW-1:0] H_S     = SW'(IMG_HEIGHT);
  localparam logic signed [SW-1:0] X_MAX_S = SW'(IMG_WIDTH - 1);
  localparam logic signed [SW-1:0] Y_MAX_S = SW'(IMG_HEIGHT - 1);

  logic signed [SW-1:0] xs_s, ys_s, x_m_s, x_p_s, y_m_s, y_p_s;

  // Signed window edges, clamped to [0, dim-1]; two guard bits keep x-OFF and x+OFF exact.
  always_comb begin
    xs_s  = $signed({2'b00, x});
    ys_s  = $signed({2'b00, y});
    x_m_s = xs_s - OFF_S;
    x_p_s = xs_s + OFF_S;
    y_m_s = ys_s - OFF_S;
    y_p_s = ys_s + OFF_S;

    if (x_m_s < ZERO_S) begin
      x_lo = '0;
    end else begin
      x_lo = x_m_s[COORD_BITS-1:0];
    end
    if (x_p_s > X_MAX_S) begin
      x_hi = X_MAX_S[COORD_BITS-1:0];
    end else begin
      x_hi = x_p_s[COORD_BITS-1:0];
    end
    if (y_m_s < ZERO_S) begin
      y_lo = '0;
    end else begin
      y_lo = y_m_s[COORD_BITS-1:0];
    end
    if (y_p_s > Y_MAX_S) begin
      y_hi = Y_MAX_S[COORD_BITS-1:0];
    end else begin
      y_hi = y_p_s[COORD_BITS-1:0];
    end

    oob = (xs_s >= W_S) || (ys_s >= H_S);
  end

endmodule

// File: rtl/conv2d_update_sequencer.sv
// Accepts one spike event, then streams one update command per in-bounds kernel tap, x fastest.
module conv2d_update_sequencer
  import conv2d_update_sequencer_pkg::*;
#(
  parameter int COORD_BITS  = 8,
  parameter int IN_CHANNELS = 4,
  parameter int IMG_WIDTH   = 32,
  parameter int IMG_HEIGHT  = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int TAP_BITS    = tap_bits(KERNEL_SIZE)
) (
  input  logic clk,
  input  logic rst,
  conv2d_update_sequencer_if.slave bus,
  output logic busy,
  output logic err_oob
);

  logic [0:0]             state_r;
  logic [COORD_BITS-1:0]  cx_r, cy_r, x_lo_r, x_hi_r, y_hi_r;
  logic                   event_ready_r, busy_r, err_oob_r;
  logic                   upd_valid_r, upd_last_r;
  logic [COORD_BITS-1:0]  upd_x_r, upd_y_r;
  logic [TAP_BITS-1:0]    upd_tap_r;
  logic [IN_CHANNELS-1:0] upd_spikes_r;

  logic [COORD_BITS-1:0]  x_lo_s, x_hi_s, y_lo_s, y_hi_s;
  logic                   oob_s;
  logic [COORD_BITS-1:0]  nx_s, ny_s;
  logic [TAP_BITS-1:0]    ntap_s, first_tap_s;
  logic                   nlast_s, first_last_s;

  function automatic logic [TAP_BITS-1:0] tap_of(
    input logic [COORD_BITS-1:0] cx,
    input logic [COORD_BITS-1:0] cy,
    input logic [COORD_BITS-1:0] ex,
    input logic [COORD_BITS-1:0] ey
  );
    int dx, dy;
    dx = int'(cx) - int'(ex) + KERNEL_SIZE / 2;
    dy = int'(cy) - int'(ey) + KERNEL_SIZE / 2;
    return TAP_BITS'(dy * KERNEL_SIZE + dx);
  endfunction

  conv2d_update_sequencer_chk #(
    .COORD_BITS (COORD_BITS),
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .KERNEL_SIZE(KERNEL_SIZE)
  ) u_chk ();

  conv2d_update_sequencer_kernel_window_clip #(
    .COORD_BITS (COORD_BITS),
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .KERNEL_SIZE(KERNEL_SIZE)
  ) u_clip (
    .x   (bus.event_x),
    .y   (bus.event_y),
    .x_lo(x_lo_s),
    .x_hi(x_hi_s),
    .y_lo(y_lo_s),
    .y_hi(y_hi_s),
    .oob (oob_s)
  );

  // Cursor step after a handshake, plus the first command of a freshly accepted event.
  always_comb begin
    if (upd_x_r == x_hi_r) begin
      nx_s = x_lo_r;
      ny_s = upd_y_r + COORD_BITS'(1);
    end else begin
      nx_s = upd_x_r + COORD_BITS'(1);
      ny_s = upd_y_r;
    end
    ntap_s       = tap_of(nx_s, ny_s, cx_r, cy_r);
    nlast_s      = (nx_s == x_hi_r) && (ny_s == y_hi_r);
    first_tap_s  = tap_of(x_lo_s, y_lo_s, bus.event_x, bus.event_y);
    first_last_s = (x_lo_s == x_hi_s) && (y_lo_s == y_hi_s);
  end

  // Sequencer FSM; the output registers hold the command currently offered downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      cx_r          <= '0;
      cy_r          <= '0;
      x_lo_r        <= '0;
      x_hi_r        <= '0;
      y_hi_r        <= '0;
      event_ready_r <= 1'b0;
      busy_r        <= 1'b0;
      err_oob_r     <= 1'b0;
      upd_valid_r   <= 1'b0;
      upd_last_r    <= 1'b0;
      upd_x_r       <= '0;
      upd_y_r       <= '0;
      upd_tap_r     <= '0;
      upd_spikes_r  <= '0;
    end else begin
      err_oob_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.event_valid && event_ready_r) begin
            if (oob_s) begin
              err_oob_r     <= 1'b1;
              event_ready_r <= 1'b1;
            end else begin
              state_r       <= ST_SCAN;
              cx_r          <= bus.event_x;
              cy_r          <= bus.event_y;
              x_lo_r        <= x_lo_s;
              x_hi_r        <= x_hi_s;
              y_hi_r        <= y_hi_s;
              event_ready_r <= 1'b0;
              busy_r        <= 1'b1;
              upd_valid_r   <= 1'b1;
              upd_x_r       <= x_lo_s;
              upd_y_r       <= y_lo_s;
              upd_tap_r     <= first_tap_s;
              upd_last_r    <= first_last_s;
              upd_spikes_r  <= bus.event_spikes;
            end
          end else begin
            event_ready_r <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (upd_valid_r && bus.upd_ready) begin
            if (upd_last_r) begin
              state_r       <= ST_IDLE;
              upd_valid_r   <= 1'b0;
              upd_last_r    <= 1'b0;
              busy_r        <= 1'b0;
              event_ready_r <= 1'b1;
            end else begin
              upd_x_r    <= nx_s;
              upd_y_r    <= ny_s;
              upd_tap_r  <= ntap_s;
              upd_last_r <= nlast_s;
            end
          end else begin
            upd_valid_r <= upd_valid_r;
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          upd_valid_r   <= 1'b0;
          upd_last_r    <= 1'b0;
          busy_r        <= 1'b0;
          event_ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.event_ready = event_ready_r;
  assign bus.upd_valid   = upd_valid_r;
  assign bus.upd_x       = upd_x_r;
  assign bus.upd_y       = upd_y_r;
  assign bus.upd_tap     = upd_tap_r;
  assign bus.upd_spikes  = upd_spikes_r;
  assign bus.upd_last    = upd_last_r;
  assign busy            = busy_r;
  assign err_oob         = err_oob_r;

endmodule

// File: tb/tb_conv2d_update_sequencer.sv
// Self-checking bench: event table plus scoreboard for K=3, hand sequences for stall/oob/reset and K=5.
module tb_conv2d_update_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv2d_update_sequencer_if #(.COORD_BITS(8), .IN_CHANNELS(4), .KERNEL_SIZE(3)) bus3 ();
  conv2d_update_sequencer_if #(.COORD_BITS(8), .IN_CHANNELS(4), .KERNEL_SIZE(5)) bus5 ();
  logic busy3, err3, busy5, err5;

  conv2d_update_sequencer #(
    .COORD_BITS(8), .IN_CHANNELS(4), .IMG_WIDTH(32), .IMG_HEIGHT(32), .KERNEL_SIZE(3)
  ) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave), .busy(busy3), .err_oob(err3));

  conv2d_update_sequencer #(
    .COORD_BITS(8), .IN_CHANNELS(4), .IMG_WIDTH(32), .IMG_HEIGHT(32), .KERNEL_SIZE(5)
  ) dut5 (.clk(clk), .rst(rst), .bus(bus5.slave), .busy(busy5), .err_oob(err5));

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] tap;
    logic [3:0] sp;
    logic       last;
  } upd_t;

  typedef struct {
    int         ex, ey;
    logic [3:0] sp;
    int         n;
    int         fx, fy, ft;
    int         lx, ly, lt;
  } vec_t;

  upd_t sb3[$];
  upd_t sb5[$];
  int   errors = 0;
  int   checks = 0;
  int   mon_cnt = 0;
  upd_t mon_first, mon_lastu, held3, c3, e3, c5, e5;
  bit   hold_pend = 1'b0;
  vec_t vt[5];
  int   cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference window walk: clip to 32x32, row-major, x fastest.
  function automatic void model(input int ex, input int ey, input int k, input logic [3:0] sp, input bit to5);
    int   off, xl, xh, yl, yh;
    upd_t u;
    off = k / 2;
    xl = (ex - off < 0) ? 0 : ex - off;
    xh = (ex + off > 31) ? 31 : ex + off;
    yl = (ey - off < 0) ? 0 : ey - off;
    yh = (ey + off > 31) ? 31 : ey + off;
    for (int yy = yl; yy <= yh; yy++) begin
      for (int xx = xl; xx <= xh; xx++) begin
        u.x    = 8'(xx);
        u.y    = 8'(yy);
        u.tap  = 8'((yy - ey + off) * k + (xx - ex + off));
        u.sp   = sp;
        u.last = (xx == xh) && (yy == yh);
        if (to5) sb5.push_back(u);
        else     sb3.push_back(u);
      end
    end
  endfunction

  function automatic upd_t get3();
    upd_t u;
    u.x = bus3.upd_x; u.y = bus3.upd_y; u.tap = 8'(bus3.upd_tap);
    u.sp = bus3.upd_spikes; u.last = bus3.upd_last;
    return u;
  endfunction

  function automatic upd_t get5();
    upd_t u;
    u.x = bus5.upd_x; u.y = bus5.upd_y; u.tap = 8'(bus5.upd_tap);
    u.sp = bus5.upd_spikes; u.last = bus5.upd_last;
    return u;
  endfunction

  // Scoreboard monitor for the K=3 instance: pops on each handshake, checks stability under stall.
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      c3 = get3();
      if (hold_pend) begin
        check("stall_hold", c3, held3);
        check("stall_valid", bus3.upd_valid, 1'b1);
      end
      if (bus3.upd_valid && bus3.upd_ready) begin
        if (mon_cnt == 0) mon_first = c3;
        mon_lastu = c3;
        mon_cnt++;
        checks++;
        if (sb3.size() == 0) begin
          errors++;
          $display("FAIL unexpected_update: got %h expected none", c3);
        end else begin
          e3 = sb3.pop_front();
          if (c3 !== e3) begin
            errors++;
            $display("FAIL upd_cmd: got %h expected %h", c3, e3);
          end
        end
      end
      hold_pend = bus3.upd_valid && !bus3.upd_ready;
      held3 = c3;
    end
  end

  task automatic send3(input int ex, input int ey, input logic [3:0] sp);
    @(posedge clk); #1;
    mon_cnt = 0;
    if (ex < 32 && ey < 32) model(ex, ey, 3, sp, 1'b0);
    bus3.event_valid  = 1'b1;
    bus3.event_x      = 8'(ex);
    bus3.event_y      = 8'(ey);
    bus3.event_spikes = sp;
    @(posedge clk); #1;
    bus3.event_valid  = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget, output int n);
    n = 0;
    while (1) begin
      @(negedge clk);
      if (bus3.event_ready) break;
      if (n >= budget) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout: got busy after %0d cycles expected idle", name, n);
        break;
      end
      @(posedge clk);
      n++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{10, 10, 4'hA, 9,  9,  9, 0, 11, 11, 8};
    vt[1] = '{ 0,  0, 4'h3, 4,  0,  0, 4,  1,  1, 8};
    vt[2] = '{31, 31, 4'h5, 4, 30, 30, 0, 31, 31, 4};
    vt[3] = '{31,  0, 4'hF, 4, 30,  0, 3, 31,  1, 7};
    vt[4] = '{ 0, 15, 4'h1, 6,  0, 14, 1,  1, 16, 8};

    rst = 1'b1;
    bus3.event_valid = 1'b0; bus3.event_x = '0; bus3.event_y = '0; bus3.event_spikes = '0;
    bus3.upd_ready = 1'b1;
    bus5.event_valid = 1'b0; bus5.event_x = '0; bus5.event_y = '0; bus5.event_spikes = '0;
    bus5.upd_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_event_ready", bus3.event_ready, 1'b0);
    check("rst_upd_valid", bus3.upd_valid, 1'b0);
    check("rst_busy", busy3, 1'b0);
    check("rst_err_oob", err3, 1'b0);
    check("rst_upd_fields", get3(), 37'h0);
    check("rst_k5_valid", bus5.upd_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_ready", bus3.event_ready, 1'b1);

    // Table-driven events with full downstream acceptance.
    for (int i = 0; i < 5; i++) begin
      send3(vt[i].ex, vt[i].ey, vt[i].sp);
      wait_idle("table", 40, cyc);
      check("table_latency", cyc, vt[i].n);
      check("table_count", mon_cnt, vt[i].n);
      check("table_first", {mon_first.x, mon_first.y, mon_first.tap},
            {8'(vt[i].fx), 8'(vt[i].fy), 8'(vt[i].ft)});
      check("table_last", {mon_lastu.x, mon_lastu.y, mon_lastu.tap, mon_lastu.last},
            {8'(vt[i].lx), 8'(vt[i].ly), 8'(vt[i].lt), 1'b1});
      check("table_drained", sb3.size(), 0);
    end

    // Three-cycle stall on the second command of a centre event.
    send3(10, 10, 4'h6);
    @(posedge clk); #1;
    bus3.upd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_cmd", {bus3.upd_x, bus3.upd_y, 8'(bus3.upd_tap)}, {8'd10, 8'd9, 8'd1});
      check("stall_busy", busy3, 1'b1);
      @(posedge clk); #1;
    end
    bus3.upd_ready = 1'b1;
    wait_idle("stall", 40, cyc);
    check("stall_count", mon_cnt, 9);
    check("stall_drained", sb3.size(), 0);

    // Out-of-image events are rejected with a single-cycle pulse.
    send3(40, 5, 4'h2);
    @(negedge clk);
    check("oob_pulse", err3, 1'b1);
    check("oob_no_valid", bus3.upd_valid, 1'b0);
    check("oob_ready", bus3.event_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("oob_pulse_end", {err3, bus3.upd_valid, bus3.event_ready}, 3'b001);
    end
    send3(7, 32, 4'h2);
    @(negedge clk);
    check("oob_y_pulse", err3, 1'b1);

    // Normal event after rejection; a second event offered mid-scan must be ignored.
    send3(5, 5, 4'hC);
    bus3.event_valid = 1'b1; bus3.event_x = 8'd20; bus3.event_y = 8'd20;
    @(negedge clk);
    check("scan_not_ready", bus3.event_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    bus3.event_valid = 1'b0;
    wait_idle("after_oob", 40, cyc);
    check("after_oob_count", mon_cnt, 9);
    check("after_oob_first", {mon_first.x, mon_first.y, mon_first.tap}, {8'd4, 8'd4, 8'd0});
    check("after_oob_drained", sb3.size(), 0);

    // Reset after the third handshake aborts the event.
    send3(10, 10, 4'h9);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    bus3.upd_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    bus3.upd_ready = 1'b1;
    sb3.delete();
    @(negedge clk);
    check("abort_valid", bus3.upd_valid, 1'b0);
    check("abort_busy", busy3, 1'b0);
    check("abort_count", mon_cnt, 3);
    send3(10, 10, 4'h9);
    wait_idle("restart", 40, cyc);
    check("restart_count", mon_cnt, 9);
    check("restart_first", {mon_first.x, mon_first.y, mon_first.tap}, {8'd9, 8'd9, 8'd0});
    check("restart_drained", sb3.size(), 0);

    // K=5 at (1,30): x clips to 0..3, y to 28..31 -> 16 commands.
    @(posedge clk); #1;
    model(1, 30, 5, 4'h7, 1'b1);
    bus5.event_valid = 1'b1; bus5.event_x = 8'd1; bus5.event_y = 8'd30; bus5.event_spikes = 4'h7;
    @(posedge clk); #1;
    bus5.event_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      c5 = get5();
      check("k5_valid", {bus5.upd_valid, busy5, err5}, 3'b110);
      if (sb5.size() > 0) begin
        e5 = sb5.pop_front();
        check("k5_cmd", c5, e5);
      end
      if (i == 0)  check("k5_first", {c5.x, c5.y, c5.tap, c5.last}, {8'd0, 8'd28, 8'd1, 1'b0});
      if (i == 15) check("k5_last", {c5.x, c5.y, c5.tap, c5.last}, {8'd3, 8'd31, 8'd19, 1'b1});
      @(posedge clk);
    end
    @(negedge clk);
    check("k5_done", {bus5.upd_valid, bus5.event_ready, busy5}, 3'b010);
    check("k5_drained", sb5.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
